// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment scan driver.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Width of a down-counter able to hold the longer of the two intervals.
  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m + 1);
  endfunction

  // Standard gfedcba encodings for hex digits, index 0 = digit 0.
  localparam logic [15:0][6:0] SEG7_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
    return SEG7_HEX[nib];
  endfunction

endpackage

// File: rtl/seg_frame_buffer.sv
// Double buffer for the display pattern: loads land in pending and are
// promoted to active only at a frame boundary, so a frame never tears.
module seg_frame_buffer #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             promote,
  input  logic [WIDTH-1:0] seg_data,
  output logic [WIDTH-1:0] active_nxt,
  output logic             update_pending
);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active;

  // Value active takes at the next edge; a coincident load bypasses pending.
  always_comb begin
    active_nxt = active;
    if (promote && (load || update_pending)) begin
      active_nxt = load ? seg_data : pending;
    end
  end

  // Buffer registers and the pending flag; a boundary always clears the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending        <= '0;
      active         <= '0;
      update_pending <= 1'b0;
    end else begin
      if (load) begin
        pending <= seg_data;
      end
      active <= active_nxt;
      if (promote) begin
        update_pending <= 1'b0;
      end else if (load) begin
        update_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with blanking and
// double-buffered frame updates.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | enable low; outputs dark, index and counter at 0
//   ST_BLANK | all digits dark for BLANK_CYCLES before the next digit
//   ST_SHOW  | digit idx lit with its pattern for DWELL_CYCLES
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int SEGS         = 7,
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   invert,
  input  logic [DIGITS*SEGS-1:0] seg_data,
  input  logic                   load,
  output logic [DIGITS-1:0]      digit_sel,
  output logic [SEGS-1:0]        segments,
  output logic                   frame_start,
  output logic                   update_pending
);

  localparam int CW = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD = HAS_BLANK ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  scan_state_t           state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_inc;
  logic                  primed;
  logic [DIGITS-1:0]     dsel_raw;
  logic [SEGS-1:0]       seg_raw;
  logic                  frame_wrap;
  logic                  boundary;
  logic [DIGITS*SEGS-1:0] active_nxt;

  // primed is low after reset and in IDLE, so the first enabled edge
  // always starts a fresh frame.
  assign idx_inc    = idx + IW'(1);
  assign frame_wrap = primed && (state == ST_SHOW) && (cnt == '0) && (idx == LAST_IDX);
  assign boundary   = enable && (!primed || frame_wrap);

  seg_frame_buffer #(
    .WIDTH(DIGITS * SEGS)
  ) u_frame_buffer (
    .clk           (clk),
    .reset         (reset),
    .load          (load),
    .promote       (boundary),
    .seg_data      (seg_data),
    .active_nxt    (active_nxt),
    .update_pending(update_pending)
  );

  // Scan FSM with down-counter dwell/blank timing and registered raw outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_BLANK;
      cnt         <= '0;
      idx         <= '0;
      primed      <= 1'b0;
      dsel_raw    <= '0;
      seg_raw     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!enable) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        idx      <= '0;
        primed   <= 1'b0;
        dsel_raw <= '0;
        seg_raw  <= '0;
      end else if (boundary) begin
        primed      <= 1'b1;
        idx         <= '0;
        frame_start <= 1'b1;
        if (HAS_BLANK) begin
          state    <= ST_BLANK;
          cnt      <= BLANK_LOAD;
          dsel_raw <= '0;
          seg_raw  <= '0;
        end else begin
          state    <= ST_SHOW;
          cnt      <= DWELL_LOAD;
          dsel_raw <= DIGITS'(1);
          seg_raw  <= active_nxt[SEGS-1:0];
        end
      end else begin
        case (state)
          ST_BLANK: begin
            if (cnt == '0) begin
              state    <= ST_SHOW;
              cnt      <= DWELL_LOAD;
              dsel_raw <= DIGITS'(1) << idx;
              seg_raw  <= active_nxt[int'(idx)*SEGS +: SEGS];
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_SHOW: begin
            if (cnt == '0) begin
              idx <= idx_inc;
              if (HAS_BLANK) begin
                state    <= ST_BLANK;
                cnt      <= BLANK_LOAD;
                dsel_raw <= '0;
                seg_raw  <= '0;
              end else begin
                state    <= ST_SHOW;
                cnt      <= DWELL_LOAD;
                dsel_raw <= DIGITS'(1) << idx_inc;
                seg_raw  <= active_nxt[int'(idx_inc)*SEGS +: SEGS];
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: begin
            state    <= ST_IDLE;
            primed   <= 1'b0;
            dsel_raw <= '0;
            seg_raw  <= '0;
          end
        endcase
      end
    end
  end

  // Polarity is static configuration, so it is applied after the registers.
  always_comb begin
    digit_sel = dsel_raw ^ {DIGITS{invert}};
    segments  = seg_raw ^ {SEGS{invert}};
  end

endmodule
